imm_extend_pipe: RTL and testbench
==================================

Name: imm_extend_pipe

Overview:
- Parametrised immediate-extension stage for the pipelined CPU.
- Widens an IN_W-bit instruction immediate to OUT_W bits in one of four modes: sign, zero, upper/LUI, and shifted branch offset.
- Registers the result behind a valid/ready handshake with a 2-entry skid buffer, so the decode stage can stall without losing an immediate.
- Carries an optional tag (e.g. destination register index) alongside the data.

Parameters:
- IN_W, 16, immediate input width.
- OUT_W, 32, extended output width; constraint OUT_W >= IN_W + SHIFT.
- SHIFT, 2, left-shift amount applied in branch mode.
- TAG_W, 5, width of the pass-through tag; minimum 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous pipeline flush, highest priority.
- in_valid  input  1  input immediate valid.
- in_ready  output  1  stage can accept an input this cycle.
- in_imm  input  IN_W  raw immediate field.
- in_mode  input  2  extension mode: 00 sign, 01 zero, 10 upper, 11 branch.
- in_tag  input  TAG_W  sideband tag carried with the immediate.
- out_valid  output  1  out_data/out_tag valid.
- out_ready  input  1  consumer accepts the output this cycle.
- out_data  output  OUT_W  extended immediate.
- out_tag  output  TAG_W  tag matching out_data.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: out_valid=0, out_data=0, out_tag=0, in_ready=1; internal state EMPTY; skid entry cleared.
- Handshake:
  - Input fire = in_valid & in_ready.
  - Output fire = out_valid & out_ready.
  - Inputs are sampled only on fire.
  - Once out_valid=1, out_data and out_tag stay stable until output fire or flush.
- Extension, combinational on in_imm before the register:
  - 00 sign: {(OUT_W-IN_W){in_imm[IN_W-1]}, in_imm}.
  - 01 zero: {(OUT_W-IN_W){1'b0}, in_imm}.
  - 10 upper: in_imm placed in bits [OUT_W-1 : OUT_W-IN_W]; all lower bits 0.
  - 11 branch: the sign-extended value shifted left by SHIFT; low SHIFT bits 0; bits shifted past OUT_W-1 are discarded.
- Latency: 1 cycle from input fire to out_valid when the stage was EMPTY, or when it was ONE and the output also fires that cycle.
- States (main register = out_*, skid register = hidden):
  - EMPTY, out_valid=0:
    - input fire -> ONE, main loaded.
  - ONE, out_valid=1:
    - input fire & output fire -> ONE, main reloaded with the new value.
    - input fire & no output fire -> TWO, new value goes to skid.
    - output fire & no input fire -> EMPTY.
    - neither -> hold.
  - TWO, out_valid=1:
    - output fire -> ONE, main <= skid.
    - otherwise hold.
- in_ready is a registered signal and is 0 exactly when the state is TWO. It therefore never depends combinationally on out_ready.
- Ordering: strict FIFO order. No value is lost or duplicated under any pattern of in_valid and out_ready.
- Flush:
  - Forces EMPTY on the next edge regardless of state or handshakes.
  - Clears out_data/out_tag to 0 and sets in_ready=1.
  - A same-cycle in_valid is discarded.
  - A same-cycle out_ready is irrelevant: the consumer may still count that cycle's output fire, because out_valid was 1 during it.
- Reset mid-operation: immediate return to reset values; no partial state survives.
- Unused mode encodings: none, since all four are defined.

Test Plan:
- Modes, IN_W=16, OUT_W=32, SHIFT=2, out_ready=1:
  - sign 0x8000 -> 0xFFFF8000.
  - zero 0x8000 -> 0x00008000.
  - upper 0x1234 -> 0x12340000.
  - branch 0xFFFF -> 0xFFFFFFFC.
  - branch 0x7FFF -> 0x0001FFFC.
  - Each appears 1 cycle after input fire with its tag.
- Back-pressure: out_ready=0; offer tags 1, 2, 3 on consecutive cycles.
  - Tags 1 and 2 are accepted; in_ready=0 from the cycle after tag 2 is accepted; tag 3 is held.
  - Raise out_ready: outputs appear in order 1, 2, 3 with no gaps once flowing; in_ready returns to 1 one cycle after the first output fire.
- Streaming: in_valid and out_ready held at 1 for 8 cycles with immediates 0..7.
  - Throughput 1 per cycle; outputs 0..7 in order; the stage never enters TWO.
- Flush in TWO: fill both entries (out_ready=0), then assert flush together with in_valid=1 (imm 0x00AA).
  - Next cycle: out_valid=0, out_data=0, in_ready=1.
  - 0x00AA never appears on the output.
- Async reset: drop rst_n mid-cycle while in TWO.
  - Outputs go to reset values without waiting for a clk edge.
  - After release, the first input (imm 0x0001, sign mode) produces out_data 0x00000001 one cycle after input fire.

Source files
------------

// File: rtl/imm_extend_pipe_if.sv
`default_nettype none
// ============================================================================
// Module  : imm_extend_pipe_if
// Brief   : Input/output handshake bundle for the immediate-extension stage.
// Revision: 1.0
// ============================================================================
interface imm_extend_pipe_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_imm;
    logic [1:0]       in_mode;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_imm, in_mode, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  in_valid, in_imm, in_mode, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );
endinterface
`default_nettype wire

// File: rtl/imm_extend_pipe.sv
`default_nettype none
// ============================================================================
// Module  : imm_extend_pipe
// Brief   : Sign/zero/upper/branch immediate extension behind a 2-entry skid.
// Revision: 1.0
// ============================================================================
module imm_extend_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int SHIFT = 2,
    parameter int TAG_W = 5
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          flush,
    imm_extend_pipe_if.slave   bus
);
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic [OUT_W-1:0] main_data_q, main_data_d;
    logic [TAG_W-1:0] main_tag_q, main_tag_d;
    logic [OUT_W-1:0] skid_data_q, skid_data_d;
    logic [TAG_W-1:0] skid_tag_q, skid_tag_d;

    logic [OUT_W-1:0] w_sext;
    logic [OUT_W-1:0] w_ext;
    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_out_valid;

    assign w_sext = OUT_W'($signed(bus.in_imm));

    always_comb begin
        w_ext = w_sext;
        case (bus.in_mode)
            2'b00:   w_ext = w_sext;
            2'b01:   w_ext = OUT_W'(bus.in_imm);
            2'b10:   w_ext = OUT_W'(bus.in_imm) << (OUT_W - IN_W);
            default: w_ext = w_sext << SHIFT;
        endcase
    end

    assign w_out_valid = (state_q != S_EMPTY);
    assign w_in_fire   = bus.in_valid & in_ready_q;
    assign w_out_fire  = w_out_valid & bus.out_ready;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_tag_d  = main_tag_q;
        skid_data_d = skid_data_q;
        skid_tag_d  = skid_tag_q;

        case (state_q)
            S_EMPTY: begin
                if (w_in_fire) begin
                    state_d     = S_ONE;
                    main_data_d = w_ext;
                    main_tag_d  = bus.in_tag;
                end
            end
            S_ONE: begin
                if (w_in_fire && w_out_fire) begin
                    main_data_d = w_ext;
                    main_tag_d  = bus.in_tag;
                end else if (w_in_fire) begin
                    state_d     = S_TWO;
                    skid_data_d = w_ext;
                    skid_tag_d  = bus.in_tag;
                end else if (w_out_fire) begin
                    state_d     = S_EMPTY;
                end
            end
            S_TWO: begin
                // in_ready is low here, so only the drain path can move
                if (w_out_fire) begin
                    state_d     = S_ONE;
                    main_data_d = skid_data_q;
                    main_tag_d  = skid_tag_q;
                end
            end
            default: state_d = S_EMPTY;
        endcase

        if (flush) begin
            state_d     = S_EMPTY;
            main_data_d = '0;
            main_tag_d  = '0;
            skid_data_d = '0;
            skid_tag_d  = '0;
        end

        in_ready_d = (state_d != S_TWO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_EMPTY;
            in_ready_q  <= 1'b1;
            main_data_q <= '0;
            main_tag_q  <= '0;
            skid_data_q <= '0;
            skid_tag_q  <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            main_data_q <= main_data_d;
            main_tag_q  <= main_tag_d;
            skid_data_q <= skid_data_d;
            skid_tag_q  <= skid_tag_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = main_data_q;
    assign bus.out_tag   = main_tag_q;
endmodule
`default_nettype wire

// File: tb/tb_imm_extend_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_imm_extend_pipe
// Brief   : Scoreboard bench for imm_extend_pipe (modes, stalls, flush, reset).
// Revision: 1.0
// ============================================================================
module tb_imm_extend_pipe;
    localparam int c_IN_W  = 16;
    localparam int c_OUT_W = 32;
    localparam int c_SHIFT = 2;
    localparam int c_TAG_W = 5;

    logic r_clk;
    logic r_rst_n;
    logic r_flush;
    int   n_vec;
    int   n_err;
    logic [c_TAG_W+c_OUT_W-1:0] sb_q[$];

    imm_extend_pipe_if #(.IN_W(c_IN_W), .OUT_W(c_OUT_W), .TAG_W(c_TAG_W)) bus ();

    imm_extend_pipe #(
        .IN_W (c_IN_W),
        .OUT_W(c_OUT_W),
        .SHIFT(c_SHIFT),
        .TAG_W(c_TAG_W)
    ) u_dut (
        .clk  (r_clk),
        .rst_n(r_rst_n),
        .flush(r_flush),
        .bus  (bus.slave)
    );

    initial r_clk = 1'b0;
    always #5 r_clk = ~r_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] m, input logic [15:0] imm);
        case (m)
            2'b00:   return {{16{imm[15]}}, imm};
            2'b01:   return {16'h0000, imm};
            2'b10:   return {imm, 16'h0000};
            default: return {{14{imm[15]}}, imm, 2'b00};
        endcase
    endfunction

    // Scoreboard: drain side is handled before fill side so that an output
    // fire in a flush cycle is still credited.
    always @(negedge r_clk) begin
        logic [c_TAG_W+c_OUT_W-1:0] e;
        if (!r_rst_n) begin
            sb_q.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("spurious_out", {27'd0, bus.out_tag, bus.out_data}, 64'hDEAD);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_data", 64'(bus.out_data), 64'(e[c_OUT_W-1:0]));
                    chk("sb_tag", 64'(bus.out_tag), 64'(e[c_TAG_W+c_OUT_W-1:c_OUT_W]));
                end
            end
            if (r_flush) begin
                sb_q.delete();
            end else if (bus.in_valid && bus.in_ready) begin
                sb_q.push_back({bus.in_tag, model(bus.in_mode, bus.in_imm)});
            end
        end
    end

    task automatic tick();
        @(posedge r_clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] m, input logic [15:0] imm, input logic [4:0] t);
        bus.in_valid = v;
        bus.in_mode  = m;
        bus.in_imm   = imm;
        bus.in_tag   = t;
    endtask

    // Single transfer with out_ready=1; checks the fixed expected value one cycle later.
    task automatic send_mode(input string tag, input logic [1:0] m, input logic [15:0] imm,
                             input logic [4:0] t, input logic [31:0] expv);
        drive(1'b1, m, imm, t);
        @(negedge r_clk);
        chk({tag, "_rdy"}, 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        @(negedge r_clk);
        chk({tag, "_vld"}, 64'(bus.out_valid), 64'd1);
        chk({tag, "_data"}, 64'(bus.out_data), 64'(expv));
        chk({tag, "_tag"}, 64'(bus.out_tag), 64'(t));
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        r_rst_n = 1'b0;
        r_flush = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b0, 2'b00, 16'h0000, 5'd0);
        repeat (2) @(posedge r_clk);
        #3;
        chk("rst_vld", 64'(bus.out_valid), 64'd0);
        chk("rst_data", 64'(bus.out_data), 64'd0);
        chk("rst_tag", 64'(bus.out_tag), 64'd0);
        chk("rst_rdy", 64'(bus.in_ready), 64'd1);
        r_rst_n = 1'b1;
        tick();

        send_mode("sign", 2'b00, 16'h8000, 5'd3, 32'hFFFF8000);
        send_mode("zero", 2'b01, 16'h8000, 5'd4, 32'h00008000);
        send_mode("upper", 2'b10, 16'h1234, 5'd5, 32'h12340000);
        send_mode("brn_neg", 2'b11, 16'hFFFF, 5'd6, 32'hFFFFFFFC);
        send_mode("brn_pos", 2'b11, 16'h7FFF, 5'd7, 32'h0001FFFC);

        // Back-pressure: two accepted, third held until drain starts.
        bus.out_ready = 1'b0;
        drive(1'b1, 2'b00, 16'h0011, 5'd1);
        tick();
        drive(1'b1, 2'b00, 16'h0022, 5'd2);
        tick();
        drive(1'b1, 2'b00, 16'h0033, 5'd3);
        @(negedge r_clk);
        chk("bp_rdy0", 64'(bus.in_ready), 64'd0);
        tick();
        @(negedge r_clk);
        chk("bp_rdy0b", 64'(bus.in_ready), 64'd0);
        chk("bp_hold_tag", 64'(bus.out_tag), 64'd1);
        tick();
        bus.out_ready = 1'b1;
        @(negedge r_clk);
        chk("bp_out1", 64'(bus.out_tag), 64'd1);
        tick();
        @(negedge r_clk);
        chk("bp_rdy_back", 64'(bus.in_ready), 64'd1);
        chk("bp_out2_vld", 64'(bus.out_valid), 64'd1);
        chk("bp_out2", 64'(bus.out_tag), 64'd2);
        tick();
        bus.in_valid = 1'b0;
        @(negedge r_clk);
        chk("bp_out3_vld", 64'(bus.out_valid), 64'd1);
        chk("bp_out3", 64'(bus.out_tag), 64'd3);
        tick();
        @(negedge r_clk);
        chk("bp_empty", 64'(bus.out_valid), 64'd0);
        tick();

        // Streaming at full rate.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 2'b01, 16'(i), 5'(i));
            @(negedge r_clk);
            chk("stream_rdy", 64'(bus.in_ready), 64'd1);
            if (i > 0) chk("stream_vld", 64'(bus.out_valid), 64'd1);
            tick();
        end
        bus.in_valid = 1'b0;
        @(negedge r_clk);
        chk("stream_last", 64'(bus.out_data), 64'd7);
        tick();
        @(negedge r_clk);
        chk("stream_empty", 64'(bus.out_valid), 64'd0);
        tick();

        // Flush while full, with a same-cycle input that must be dropped.
        bus.out_ready = 1'b0;
        drive(1'b1, 2'b00, 16'h0101, 5'd9);
        tick();
        drive(1'b1, 2'b00, 16'h0202, 5'd10);
        tick();
        drive(1'b1, 2'b00, 16'h00AA, 5'd11);
        r_flush = 1'b1;
        tick();
        r_flush = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge r_clk);
        chk("fl_vld", 64'(bus.out_valid), 64'd0);
        chk("fl_data", 64'(bus.out_data), 64'd0);
        chk("fl_rdy", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge r_clk);
            chk("fl_quiet", 64'(bus.out_valid), 64'd0);
        end
        tick();

        // Asynchronous reset while full.
        bus.out_ready = 1'b0;
        drive(1'b1, 2'b00, 16'h0303, 5'd12);
        tick();
        drive(1'b1, 2'b00, 16'h0404, 5'd13);
        tick();
        bus.in_valid = 1'b0;
        @(negedge r_clk);
        chk("ar_full", 64'(bus.in_ready), 64'd0);
        @(posedge r_clk);
        #3;
        r_rst_n = 1'b0;
        #1;
        chk("ar_vld", 64'(bus.out_valid), 64'd0);
        chk("ar_data", 64'(bus.out_data), 64'd0);
        chk("ar_tag", 64'(bus.out_tag), 64'd0);
        chk("ar_rdy", 64'(bus.in_ready), 64'd1);
        @(negedge r_clk);
        #2;
        r_rst_n = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        send_mode("ar_first", 2'b00, 16'h0001, 5'd14, 32'h00000001);

        repeat (3) tick();
        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
